// File: rtl/fmap_stream_src.sv
// Feature-map streaming source: raster-scans one map out of a sync-read memory,
// inserts zero padding rings and paces the stream with a one-entry skid register.
module fmap_stream_src #(
    parameter int N          = 8,
    parameter int INPUT_SIZE = 6,
    parameter int PADDING    = 0,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ce,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [N-1:0]      mem_rd_data,
    output logic [N-1:0]      pix_dout,
    output logic              pix_vld,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    localparam int OUT = INPUT_SIZE + 2 * PADDING;
    localparam int CW  = $clog2(OUT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic              pend_pad_q, pend_pad_d;
    logic              pend_last_q, pend_last_d;
    logic              hold_full_q, hold_full_d;
    logic [N-1:0]      hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;

    logic         issue;
    logic         interior;
    logic         last_pos;
    logic         emit;
    logic         emit_last;
    logic [N-1:0] cur_pix;
    logic [N-1:0] emit_pix;

    always_comb begin
        issue     = (state_q == S_RUN) && ce;
        interior  = (int'(row_q) >= PADDING) && (int'(row_q) < PADDING + INPUT_SIZE)
                 && (int'(col_q) >= PADDING) && (int'(col_q) < PADDING + INPUT_SIZE);
        last_pos  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        cur_pix   = pend_pad_q ? '0 : mem_rd_data;
        // A full hold register always drains first when ce returns
        emit      = ce && (hold_full_q || pend_q);
        emit_pix  = hold_full_q ? hold_data_q : cur_pix;
        emit_last = hold_full_q ? hold_last_q : pend_last_q;
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        pend_d      = issue;
        pend_pad_d  = !interior;
        pend_last_d = last_pos;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;

        if (ce) begin
            hold_full_d = 1'b0;
        end else if (pend_q) begin
            hold_full_d = 1'b1;
            hold_data_d = cur_pix;
            hold_last_d = pend_last_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = base_addr;
                end
            end
            S_RUN: begin
                if (ce) begin
                    // Interior reads are contiguous, so the address just counts up
                    if (interior) addr_d = addr_q + 1'b1;
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pos) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (emit && emit_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_pad_q  <= 1'b0;
            pend_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_pad_q  <= pend_pad_d;
            pend_last_q <= pend_last_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
        end
    end

    always_comb begin
        mem_rd_en   = issue && interior;
        mem_rd_addr = mem_rd_en ? addr_q : '0;
        pix_vld     = emit;
        pix_dout    = emit ? emit_pix : '0;
        pix_last    = emit && emit_last;
        busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
    end

endmodule
